// File: rtl/sample_window_loader.sv
// -----------------------------------------------------------------------------
// sample_window_loader
//
// Collects a stream of signed 16-bit samples into an 8-sample window for a
// downstream averager. SLIDE=0 produces disjoint blocks of 8. SLIDE=1
// produces a sliding window that advances by one sample per accept.
//
// Ports
//   CLK        : clock, all state updates on the rising edge
//   RST        : synchronous, active-high reset
//   in_data    : signed input sample
//   in_valid   : in_data is valid this cycle
//   in_ready   : block can take a sample this cycle (depends on state and
//                out_ready only)
//   flush      : drop the partial or full window and clear a..h
//   a .. h     : registered window, a = oldest sample, h = newest
//   sa         : constant shift amount for the averager (SHIFT[7:0])
//   out_valid  : a..h hold a complete window
//   out_ready  : downstream takes the window
//   fill_cnt   : number of samples held, 0..8
// -----------------------------------------------------------------------------
module sample_window_loader #(
    parameter int SLIDE = 0,
    parameter int SHIFT = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic signed [15:0]  in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic signed [15:0]  a,
    output logic signed [15:0]  b,
    output logic signed [15:0]  c,
    output logic signed [15:0]  d,
    output logic signed [15:0]  e,
    output logic signed [15:0]  f,
    output logic signed [15:0]  g,
    output logic signed [15:0]  h,
    output logic [7:0]          sa,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          fill_cnt
);

    localparam int          DATA_W = 16;
    localparam logic [7:0]  SA_VAL = 8'(SHIFT);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_FULL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                fill_cnt_q, fill_cnt_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]  win_q [8];
    logic signed [DATA_W-1:0]  win_d [8];
    logic                      do_shift;
    logic                      clear_win;
    logic                      accept;
    logic                      consume;

    // Sample count saturates at a full window.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        return (cnt >= 4'd8) ? 4'd8 : cnt + 4'd1;
    endfunction

    assign accept  = in_valid & in_ready;
    assign consume = out_valid_q & out_ready;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, also deciding what the window does this cycle
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        do_shift   = 1'b0;
        clear_win  = 1'b0;
        if (flush) begin
            // Flush wins over any handshake; a presented sample is dropped.
            state_d    = ST_FILL;
            fill_cnt_d = 4'd0;
            clear_win  = 1'b1;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        do_shift   = 1'b1;
                        fill_cnt_d = sat_inc(fill_cnt_q);
                        if (fill_cnt_q == 4'd7) begin
                            state_d = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    // in_ready follows out_ready here, so an accept always
                    // coincides with a consume.
                    if (consume) begin
                        if (SLIDE == 0) begin
                            state_d    = ST_FILL;
                            do_shift   = accept;
                            fill_cnt_d = accept ? 4'd1 : 4'd0;
                        end else if (accept) begin
                            do_shift = 1'b1;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        do_shift = 1'b1;
                        state_d  = ST_FULL;
                    end
                end
                default: begin
                    state_d    = ST_FILL;
                    fill_cnt_d = 4'd0;
                end
            endcase
        end
        out_valid_d = (state_d == ST_FULL);
    end

    // Output logic
    always_comb begin
        in_ready = 1'b1;
        if (state_q == ST_FULL) begin
            in_ready = out_ready;
        end
    end

    always_comb begin
        win_d = win_q;
        if (clear_win) begin
            for (int i = 0; i < 8; i++) begin
                win_d[i] = '0;
            end
        end else if (do_shift) begin
            for (int i = 0; i < 7; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[7] = in_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fill_cnt_q  <= 4'd0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            fill_cnt_q  <= fill_cnt_d;
            out_valid_q <= out_valid_d;
            win_q       <= win_d;
        end
    end

    assign a         = win_q[0];
    assign b         = win_q[1];
    assign c         = win_q[2];
    assign d         = win_q[3];
    assign e         = win_q[4];
    assign f         = win_q[5];
    assign g         = win_q[6];
    assign h         = win_q[7];
    assign sa        = SA_VAL;
    assign out_valid = out_valid_q;
    assign fill_cnt  = fill_cnt_q;

endmodule

// File: tb/tb_sample_window_loader.sv
// -----------------------------------------------------------------------------
// tb_sample_window_loader
//
// Two instances (block mode and sliding mode) share clock, reset and input
// stimulus; each scenario starts from reset and looks at the instance whose
// mode it exercises. Expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_sample_window_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] in_data;
    logic        in_valid;
    logic        flush;
    logic        out_ready;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [3:0]  fill0, fill1;
    logic [7:0]  sa0, sa1;
    logic [15:0] w0 [8];
    logic [15:0] w1 [8];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 CLK = ~CLK;

    sample_window_loader #(.SLIDE(0), .SHIFT(1)) u_dut0 (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .flush(flush),
        .a(w0[0]), .b(w0[1]), .c(w0[2]), .d(w0[3]),
        .e(w0[4]), .f(w0[5]), .g(w0[6]), .h(w0[7]),
        .sa(sa0), .out_valid(out_valid0), .out_ready(out_ready),
        .fill_cnt(fill0)
    );

    sample_window_loader #(.SLIDE(1), .SHIFT(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .flush(flush),
        .a(w1[0]), .b(w1[1]), .c(w1[2]), .d(w1[3]),
        .e(w1[4]), .f(w1[5]), .g(w1[6]), .h(w1[7]),
        .sa(sa1), .out_valid(out_valid1), .out_ready(out_ready),
        .fill_cnt(fill1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_data   = 16'h0000;
        tick();
        RST = 1'b0;
    endtask

    task automatic feed(input logic [15:0] v);
        in_data  = v;
        in_valid = 1'b1;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] exp16;

        // Reset state
        RST = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = 16'h0;
        tick();
        chk("rst_sa_during", {24'h0, sa0}, 32'h1);
        RST = 1'b0;
        chk("rst_valid", {31'h0, out_valid0}, 32'h0);
        chk("rst_fill", {28'h0, fill0}, 32'h0);
        chk("rst_a", {16'h0, w0[0]}, 32'h0);
        chk("rst_h1", {16'h0, w1[7]}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready0}, 32'h1);

        // Block mode, downstream always ready, 1..8
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("blk_pre_valid", {31'h0, out_valid0}, 32'h0);
            feed(16'(i));
        end
        idle();
        chk("blk_valid", {31'h0, out_valid0}, 32'h1);
        chk("blk_fill8", {28'h0, fill0}, 32'h8);
        for (int j = 0; j < 8; j++) begin
            exp16 = 16'(j + 1);
            chk("blk_win", {16'h0, w0[j]}, {16'h0, exp16});
        end
        tick();
        chk("blk_valid_drop", {31'h0, out_valid0}, 32'h0);
        chk("blk_fill0", {28'h0, fill0}, 32'h0);
        chk("blk_sa", {24'h0, sa0}, 32'h1);

        // Block mode, backpressure then consume with simultaneous accept
        do_reset();
        for (int i = 1; i <= 8; i++) feed(16'h0100 + 16'(i));
        chk("bp_valid", {31'h0, out_valid0}, 32'h1);
        in_data  = 16'h7FFF;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", {31'h0, in_ready0}, 32'h0);
            tick();
        end
        chk("bp_fill", {28'h0, fill0}, 32'h8);
        chk("bp_valid_hold", {31'h0, out_valid0}, 32'h1);
        for (int j = 0; j < 8; j++) begin
            exp16 = 16'h0101 + 16'(j);
            chk("bp_win", {16'h0, w0[j]}, {16'h0, exp16});
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_up", {31'h0, in_ready0}, 32'h1);
        tick();
        idle();
        out_ready = 1'b0;
        chk("bp_fill1", {28'h0, fill0}, 32'h1);
        chk("bp_h", {16'h0, w0[7]}, 32'h7FFF);
        chk("bp_g", {16'h0, w0[6]}, 32'h0108);
        chk("bp_valid_after", {31'h0, out_valid0}, 32'h0);

        // Sliding mode, -1..-10 continuously with downstream ready
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            feed(16'(-i));
            chk("sl_valid", {31'h0, out_valid1}, (i >= 8) ? 32'h1 : 32'h0);
        end
        idle();
        chk("sl_fill", {28'h0, fill1}, 32'h8);
        for (int j = 0; j < 8; j++) begin
            exp16 = 16'(-(j + 3));
            chk("sl_win", {16'h0, w1[j]}, {16'h0, exp16});
        end
        // consume with no new sample -> hold
        tick();
        chk("hold_valid", {31'h0, out_valid1}, 32'h0);
        chk("hold_fill", {28'h0, fill1}, 32'h8);
        chk("hold_in_ready", {31'h0, in_ready1}, 32'h1);
        chk("hold_a", {16'h0, w1[0]}, 32'hFFFD);
        out_ready = 1'b0;
        feed(16'h1234);
        idle();
        chk("hold_refull", {31'h0, out_valid1}, 32'h1);
        chk("hold_a_shift", {16'h0, w1[0]}, 32'hFFFC);
        chk("hold_g_shift", {16'h0, w1[6]}, 32'hFFF6);
        chk("hold_h_new", {16'h0, w1[7]}, 32'h1234);

        // Flush with a simultaneous sample
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) feed(16'h0050 + 16'(i));
        chk("fl_fill5", {28'h0, fill0}, 32'h5);
        flush    = 1'b1;
        in_data  = 16'hDEAD;
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("fl_fill0", {28'h0, fill0}, 32'h0);
        chk("fl_valid", {31'h0, out_valid0}, 32'h0);
        for (int j = 0; j < 8; j++) begin
            chk("fl_win0", {16'h0, w0[j]}, 32'h0);
        end
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) feed(16'h0200 + 16'(i));
        idle();
        chk("fl_clean_valid", {31'h0, out_valid0}, 32'h1);
        for (int j = 0; j < 8; j++) begin
            exp16 = 16'h0201 + 16'(j);
            chk("fl_clean_win", {16'h0, w0[j]}, {16'h0, exp16});
        end

        // Reset while full with downstream ready
        do_reset();
        for (int i = 1; i <= 8; i++) feed(16'h0300 + 16'(i));
        idle();
        chk("rf_valid_pre", {31'h0, out_valid0}, 32'h1);
        out_ready = 1'b1;
        RST       = 1'b1;
        tick();
        RST = 1'b0;
        chk("rf_valid", {31'h0, out_valid0}, 32'h0);
        chk("rf_fill", {28'h0, fill0}, 32'h0);
        chk("rf_h", {16'h0, w0[7]}, 32'h0);
        chk("rf_sa", {24'h0, sa0}, 32'h1);
        feed(16'h03AA);
        idle();
        chk("rf_first_fill", {28'h0, fill0}, 32'h1);
        chk("rf_first_h", {16'h0, w0[7]}, 32'h03AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
